cdb_arbiter: RTL and testbench

//  Consumer end of the FU done/ack result handshake. Collects completed-result

---
 rtl/cdb_arbiter.sv | 104 ++++++++++
 tb/tb_cdb_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin FU result arbiter driving a registered common data bus
module cdb_arbiter #(
  parameter int NUM_FU    = 4,
  parameter int ROB_TAG_W = 5,
  parameter int XLEN      = 32
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        squash,
  input  logic [NUM_FU-1:0]           fu_done,
  input  logic [NUM_FU*ROB_TAG_W-1:0] fu_rob_tag,
  input  logic [NUM_FU*XLEN-1:0]      fu_v,
  input  logic [NUM_FU-1:0]           fu_take_branch,
  input  logic [NUM_FU*XLEN-1:0]      fu_branch_loc,
  input  logic [NUM_FU-1:0]           fu_mispredicted,
  output logic [NUM_FU-1:0]           fu_ack,
  output logic                        cdb_valid,
  output logic [ROB_TAG_W-1:0]        cdb_rob_tag,
  output logic [XLEN-1:0]             cdb_v,
  output logic                        cdb_take_branch,
  output logic [XLEN-1:0]             cdb_branch_loc,
  output logic                        cdb_mispredicted,
  output logic [31:0]                 bcast_count
);

  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     grant_idx;
  logic [PTR_W-1:0]     next_ptr;
  logic                 grant_valid;
  logic [ROB_TAG_W-1:0] sel_tag;
  logic [XLEN-1:0]      sel_v;
  logic                 sel_take_branch;
  logic [XLEN-1:0]      sel_branch_loc;
  logic                 sel_mispredicted;
  logic                 do_bcast;

  // Scan from rr_ptr upward with wraparound; the first requester found wins.
  always_comb begin
    grant_valid      = 1'b0;
    grant_idx        = '0;
    sel_tag          = '0;
    sel_v            = '0;
    sel_take_branch  = 1'b0;
    sel_branch_loc   = '0;
    sel_mispredicted = 1'b0;
    for (int i = 0; i < NUM_FU; i++) begin
      int idx;
      idx = (int'(rr_ptr) + i) % NUM_FU;
      if (!grant_valid && fu_done[idx]) begin
        grant_valid      = 1'b1;
        grant_idx        = PTR_W'(idx);
        sel_tag          = fu_rob_tag[idx*ROB_TAG_W +: ROB_TAG_W];
        sel_v            = fu_v[idx*XLEN +: XLEN];
        sel_take_branch  = fu_take_branch[idx];
        sel_branch_loc   = fu_branch_loc[idx*XLEN +: XLEN];
        sel_mispredicted = fu_mispredicted[idx];
      end
    end
  end

  always_comb begin
    next_ptr = (grant_idx == PTR_W'(NUM_FU - 1)) ? '0 : grant_idx + 1'b1;
    do_bcast = grant_valid && !squash;
  end

  // During squash every requester is acked so the FUs drain their stale results.
  always_comb begin
    fu_ack = '0;
    if (!reset_n) begin
      fu_ack = '0;
    end else if (squash) begin
      fu_ack = fu_done;
    end else if (grant_valid) begin
      fu_ack[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr           <= '0;
      bcast_count      <= '0;
      cdb_valid        <= 1'b0;
      cdb_rob_tag      <= '0;
      cdb_v            <= '0;
      cdb_take_branch  <= 1'b0;
      cdb_branch_loc   <= '0;
      cdb_mispredicted <= 1'b0;
    end else begin
      cdb_valid <= do_bcast;
      if (do_bcast) begin
        rr_ptr           <= next_ptr;
        bcast_count      <= bcast_count + 32'd1;
        cdb_rob_tag      <= sel_tag;
        cdb_v            <= sel_v;
        cdb_take_branch  <= sel_take_branch;
        cdb_branch_loc   <= sel_branch_loc;
        cdb_mispredicted <= sel_mispredicted;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - table-driven checks of cdb_arbiter arbitration, broadcast and squash
module tb_cdb_arbiter;

  localparam int NUM_FU    = 4;
  localparam int ROB_TAG_W = 5;
  localparam int XLEN      = 32;

  logic                        clock;
  logic                        reset_n;
  logic                        squash;
  logic [NUM_FU-1:0]           fu_done;
  logic [NUM_FU*ROB_TAG_W-1:0] fu_rob_tag;
  logic [NUM_FU*XLEN-1:0]      fu_v;
  logic [NUM_FU-1:0]           fu_take_branch;
  logic [NUM_FU*XLEN-1:0]      fu_branch_loc;
  logic [NUM_FU-1:0]           fu_mispredicted;
  logic [NUM_FU-1:0]           fu_ack;
  logic                        cdb_valid;
  logic [ROB_TAG_W-1:0]        cdb_rob_tag;
  logic [XLEN-1:0]             cdb_v;
  logic                        cdb_take_branch;
  logic [XLEN-1:0]             cdb_branch_loc;
  logic                        cdb_mispredicted;
  logic [31:0]                 bcast_count;

  cdb_arbiter #(.NUM_FU(NUM_FU), .ROB_TAG_W(ROB_TAG_W), .XLEN(XLEN)) dut (
    .clock(clock), .reset_n(reset_n), .squash(squash), .fu_done(fu_done),
    .fu_rob_tag(fu_rob_tag), .fu_v(fu_v), .fu_take_branch(fu_take_branch),
    .fu_branch_loc(fu_branch_loc), .fu_mispredicted(fu_mispredicted),
    .fu_ack(fu_ack), .cdb_valid(cdb_valid), .cdb_rob_tag(cdb_rob_tag),
    .cdb_v(cdb_v), .cdb_take_branch(cdb_take_branch),
    .cdb_branch_loc(cdb_branch_loc), .cdb_mispredicted(cdb_mispredicted),
    .bcast_count(bcast_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  done;
    logic        sq;
    logic [3:0]  ack;
    logic        valid;
    int          fu;      // FU whose packet must be on the CDB next cycle, -1 = no data check
    logic [31:0] count;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  logic [4:0]  tag_tab [4] = '{5'd3, 5'd6, 5'd9, 5'd12};
  logic [31:0] v_tab   [4] = '{32'hA000, 32'hB001, 32'h1234, 32'hD003};
  logic [3:0]  tb_bits = 4'b1010;
  logic [3:0]  mp_bits = 4'b0110;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic check_cdb(input string name, input int fu);
    check({name, " tag"}, 32'(cdb_rob_tag), 32'(tag_tab[fu]));
    check({name, " v"}, cdb_v, v_tab[fu]);
    check({name, " take_branch"}, 32'(cdb_take_branch), 32'(tb_bits[fu]));
    check({name, " branch_loc"}, cdb_branch_loc, 32'h8000_0000 + 32'(fu * 4));
    check({name, " mispredicted"}, 32'(cdb_mispredicted), 32'(mp_bits[fu]));
  endtask

  initial begin
    // Fairness from rr_ptr=0
    vecs.push_back('{4'b1111, 1'b0, 4'b0001, 1'b1, 0, 32'd1});
    vecs.push_back('{4'b1111, 1'b0, 4'b0010, 1'b1, 1, 32'd2});
    vecs.push_back('{4'b1111, 1'b0, 4'b0100, 1'b1, 2, 32'd3});
    vecs.push_back('{4'b1111, 1'b0, 4'b1000, 1'b1, 3, 32'd4});
    vecs.push_back('{4'b1111, 1'b0, 4'b0001, 1'b1, 0, 32'd5});
    vecs.push_back('{4'b1111, 1'b0, 4'b0010, 1'b1, 1, 32'd6});
    vecs.push_back('{4'b1111, 1'b0, 4'b0100, 1'b1, 2, 32'd7});
    vecs.push_back('{4'b1111, 1'b0, 4'b1000, 1'b1, 3, 32'd8});
    // Single request, then wrap priority from rr_ptr=3
    vecs.push_back('{4'b0100, 1'b0, 4'b0100, 1'b1, 2, 32'd9});
    vecs.push_back('{4'b1001, 1'b0, 4'b1000, 1'b1, 3, 32'd10});
    vecs.push_back('{4'b1001, 1'b0, 4'b0001, 1'b1, 0, 32'd11});
    // Squash acks all, no broadcast; pointer stays at 1
    vecs.push_back('{4'b0110, 1'b1, 4'b0110, 1'b0, -1, 32'd11});
    vecs.push_back('{4'b0110, 1'b0, 4'b0010, 1'b1, 1, 32'd12});
    // Idle
    vecs.push_back('{4'b0000, 1'b0, 4'b0000, 1'b0, -1, 32'd12});
    vecs.push_back('{4'b0000, 1'b0, 4'b0000, 1'b0, -1, 32'd12});
    vecs.push_back('{4'b0000, 1'b0, 4'b0000, 1'b0, -1, 32'd12});
    vecs.push_back('{4'b1111, 1'b0, 4'b0100, 1'b1, 2, 32'd13});
    // Re-requester FU2 ranks last after its grant
    vecs.push_back('{4'b0101, 1'b0, 4'b0001, 1'b1, 0, 32'd14});
    vecs.push_back('{4'b0100, 1'b0, 4'b0100, 1'b1, 2, 32'd15});

    for (int i = 0; i < NUM_FU; i++) begin
      fu_rob_tag[i*ROB_TAG_W +: ROB_TAG_W] = tag_tab[i];
      fu_v[i*XLEN +: XLEN]                 = v_tab[i];
      fu_branch_loc[i*XLEN +: XLEN]        = 32'h8000_0000 + 32'(i * 4);
    end
    fu_take_branch  = tb_bits;
    fu_mispredicted = mp_bits;
    squash  = 1'b0;
    fu_done = 4'b1111;
    reset_n = 1'b0;

    #2;
    check("reset ack", 32'(fu_ack), 32'd0);
    check("reset valid", 32'(cdb_valid), 32'd0);
    check("reset count", bcast_count, 32'd0);
    check("reset tag", 32'(cdb_rob_tag), 32'd0);
    @(posedge clock);
    #1;
    check("reset held valid", 32'(cdb_valid), 32'd0);
    check("reset held count", bcast_count, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    foreach (vecs[k]) begin
      if (k != 0) @(negedge clock);
      fu_done = vecs[k].done;
      squash  = vecs[k].sq;
      #1;
      check($sformatf("vec%0d ack", k), 32'(fu_ack), 32'(vecs[k].ack));
      @(posedge clock);
      #1;
      check($sformatf("vec%0d valid", k), 32'(cdb_valid), 32'(vecs[k].valid));
      check($sformatf("vec%0d count", k), bcast_count, vecs[k].count);
      if (vecs[k].fu >= 0) check_cdb($sformatf("vec%0d cdb", k), vecs[k].fu);
    end

    // Reset pulse mid-stream with all FUs requesting
    @(negedge clock);
    fu_done = 4'b1111;
    squash  = 1'b0;
    @(posedge clock);
    #2;
    check("pre-reset valid", 32'(cdb_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    check("midreset ack", 32'(fu_ack), 32'd0);
    check("midreset valid", 32'(cdb_valid), 32'd0);
    check("midreset count", bcast_count, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("post-reset ack", 32'(fu_ack), 32'b0001);
    @(posedge clock);
    #1;
    check("post-reset valid", 32'(cdb_valid), 32'd1);
    check("post-reset count", bcast_count, 32'd1);
    check_cdb("post-reset cdb", 0);

    // Squash coinciding with reset: reset wins and ack stays low
    @(negedge clock);
    squash  = 1'b1;
    reset_n = 1'b0;
    #1;
    check("sq+reset ack", 32'(fu_ack), 32'd0);
    check("sq+reset valid", 32'(cdb_valid), 32'd0);
    check("sq+reset count", bcast_count, 32'd0);
    @(negedge clock);
    squash  = 1'b0;
    reset_n = 1'b1;
    fu_done = 4'b0000;
    @(posedge clock);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
